// File: rtl/apb_request_node_if.sv
// apb_request_node_if: local command, crossbar request/response and completion signals of one requester port
//   slave  : the request node (takes commands, drives rn_txreq/rn_valid, returns completions)
//   master : the environment (local master plus complete_node side)
interface apb_request_node_if #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_FLIT_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8,
  parameter int RSP_FLIT_WIDTH = 2 + DATA_WIDTH
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_strb;
  logic [2:0]                cmd_prot;
  logic                      cmd_nse;
  logic                      rn_valid;
  logic                      cn_ready;
  logic [REQ_FLIT_WIDTH-1:0] rn_txreq;
  logic [RSP_FLIT_WIDTH-1:0] rn_rxrsp;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse,
    input  cn_ready, rn_rxrsp, rsp_ready,
    output cmd_ready, rn_valid, rn_txreq, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse,
    output cn_ready, rn_rxrsp, rsp_ready,
    input  cmd_ready, rn_valid, rn_txreq, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_request_node.sv
// apb_request_node: packs one local command into a request flit, waits for its response or a timeout, returns the completion
//   pclk, preset : clock, asynchronous active-high reset
//   bus (slave)  : cmd_* command handshake, rn_valid/cn_ready/rn_txreq request flit, rn_rxrsp response flit, rsp_* completion
module apb_request_node #(
  parameter int         ADDR_WIDTH     = 64,
  parameter int         DATA_WIDTH     = 32,
  parameter int         REQ_FLIT_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8,
  parameter int         RSP_FLIT_WIDTH = 2 + DATA_WIDTH,
  parameter logic [1:0] NODE_ID        = 2'd0,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input logic pclk,
  input logic preset,
  apb_request_node_if.slave bus
);
  localparam int          STRB_WIDTH = DATA_WIDTH/8;
  localparam logic [15:0] T_LAST     = 16'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  state_t                    state;
  logic [15:0]               timer;
  logic                      is_write;
  logic [7:0]                hdr;
  logic [REQ_FLIT_WIDTH-1:0] flit;
  logic                      rsp_vld;
  logic                      slverr;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      timed_out;
  assign rsp_vld   = bus.rn_rxrsp[DATA_WIDTH+1];
  assign slverr    = bus.rn_rxrsp[DATA_WIDTH];
  assign rdata     = bus.rn_rxrsp[DATA_WIDTH-1:0];
  assign timed_out = (TIMEOUT_CYCLES != 0) && (timer == T_LAST);
  always_comb begin
    hdr  = {bus.cmd_write, bus.cmd_prot, bus.cmd_nse, NODE_ID, 1'b0};
    flit = bus.cmd_write ? REQ_FLIT_WIDTH'({hdr, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb})
                         : REQ_FLIT_WIDTH'({hdr, bus.cmd_addr, {(DATA_WIDTH+STRB_WIDTH){1'b0}}});
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state           <= IDLE;
      timer           <= '0;
      is_write        <= 1'b0;
      bus.cmd_ready   <= 1'b1;
      bus.rn_valid    <= 1'b0;
      bus.rn_txreq    <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          bus.rn_txreq  <= flit;
          bus.rn_valid  <= 1'b1;
          bus.cmd_ready <= 1'b0;
          is_write      <= bus.cmd_write;
          state         <= REQ;
        end
        REQ: if (bus.cn_ready) begin
          bus.rn_valid <= 1'b0;
          bus.rn_txreq <= '0;
          timer        <= '0;
          state        <= WAIT_RSP;
        end
        // a response arriving on the timeout cycle takes priority over the timeout
        WAIT_RSP: if (rsp_vld) begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_err     <= slverr;
          bus.rsp_timeout <= 1'b0;
          bus.rsp_rdata   <= is_write ? '0 : rdata;
          state           <= DONE;
        end else if (timed_out) begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_err     <= 1'b1;
          bus.rsp_timeout <= 1'b1;
          bus.rsp_rdata   <= '0;
          state           <= DONE;
        end else begin
          timer <= (timer == 16'hFFFF) ? timer : timer + 16'd1;
        end
        DONE: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_request_node.sv
// tb_apb_request_node: directed and randomized transactions against a cycle-level expectation model
module tb_apb_request_node;
  localparam int         AW  = 64;
  localparam int         DW  = 32;
  localparam int         SW  = DW/8;
  localparam int         RQW = 8 + AW + DW + SW;
  localparam int         T   = 8;
  localparam logic [1:0] NID = 2'd1;
  logic pclk   = 1'b0;
  logic preset = 1'b1;
  int   tests  = 0;
  int   fails  = 0;
  apb_request_node_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb_request_node #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_ID(NID), .TIMEOUT_CYCLES(T)) dut (
    .pclk(pclk), .preset(preset), .bus(bus.slave)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [RQW-1:0] exp_flit(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                               input logic [SW-1:0] s, input logic [2:0] p, input logic n);
    logic [RQW-1:0] f;
    int unsigned    h;
    h = (w ? 128 : 0) + int'(p) * 16 + int'(n) * 8 + int'(NID) * 2;
    f = RQW'(h) << (AW + DW + SW);
    f = f | (RQW'(a) << (DW + SW));
    if (w) f = f | (RQW'(d) << SW) | RQW'(s);
    return f;
  endfunction
  // rsp_dly: WAIT_RSP cycles before the response is presented; >= T means no response
  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                     input logic [2:0] p, input logic n, input int acc_dly, input int rsp_dly,
                     input logic slv, input logic [DW-1:0] rd, input int rdy_dly);
    logic [RQW-1:0] f;
    logic           to;
    logic           e_err;
    logic [DW-1:0]  e_rd;
    int             done_at;
    f       = exp_flit(w, a, d, s, p, n);
    to      = rsp_dly >= T;
    done_at = to ? T - 1 : rsp_dly;
    e_err   = to ? 1'b1 : slv;
    e_rd    = (to || w) ? DW'(0) : rd;
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
    bus.cmd_nse   = n;
    bus.cn_ready  = (acc_dly == 0);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = {$urandom, $urandom};
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = SW'($urandom);
    bus.cmd_prot  = 3'($urandom);
    bus.cmd_nse   = 1'($urandom);
    chk("req_valid", bus.rn_valid, 1);
    chk("req_cmd_ready", bus.cmd_ready, 0);
    chk("req_flit", bus.rn_txreq, f);
    for (int k = 0; k < acc_dly; k++) begin
      @(negedge pclk);
      chk("hold_valid", bus.rn_valid, 1);
      chk("hold_flit", bus.rn_txreq, f);
      chk("hold_rsp_valid", bus.rsp_valid, 0);
      bus.cn_ready = (k == acc_dly - 1);
    end
    @(negedge pclk);
    bus.cn_ready = 1'($urandom);
    chk("acc_valid", bus.rn_valid, 0);
    chk("acc_flit", bus.rn_txreq, 0);
    for (int j = 0; j <= done_at; j++) begin
      bus.rn_rxrsp = (j == rsp_dly) ? {1'b1, slv, rd} : {1'b0, 1'($urandom), DW'($urandom)};
      @(negedge pclk);
      chk("wait_rsp_valid", bus.rsp_valid, j == done_at);
    end
    bus.rn_rxrsp = '0;
    chk("rsp_err", bus.rsp_err, e_err);
    chk("rsp_timeout", bus.rsp_timeout, to);
    chk("rsp_rdata", bus.rsp_rdata, e_rd);
    for (int k = 0; k < rdy_dly; k++) begin
      bus.rsp_ready = 1'b0;
      bus.rn_rxrsp  = {1'b1, 1'($urandom), DW'($urandom)};
      @(negedge pclk);
      chk("done_valid", bus.rsp_valid, 1);
      chk("done_cmd_ready", bus.cmd_ready, 0);
      chk("done_err", bus.rsp_err, e_err);
      chk("done_timeout", bus.rsp_timeout, to);
      chk("done_rdata", bus.rsp_rdata, e_rd);
    end
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    chk("rel_valid", bus.rsp_valid, 0);
    chk("rel_cmd_ready", bus.cmd_ready, 1);
    bus.rn_rxrsp = {1'b1, 1'($urandom), DW'($urandom)};
    @(negedge pclk);
    bus.rn_rxrsp = '0;
    chk("idle_late_rsp", bus.rsp_valid, 0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.cmd_nse   = 1'b0;
    bus.cn_ready  = 1'b0;
    bus.rn_rxrsp  = '0;
    bus.rsp_ready = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rn_valid", bus.rn_valid, 0);
    chk("rst_txreq", bus.rn_txreq, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", {bus.rsp_err, bus.rsp_timeout}, 0);
    preset = 1'b0;
    @(negedge pclk);
    txn(1'b1, 64'h1000, 32'hDEADBEEF, 4'hF, 3'b010, 1'b0, 0, 1, 1'b0, 32'h5A5A5A5A, 0);
    txn(1'b0, 64'h2000_0040, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b1, 5, 0, 1'b0, 32'h12345678, 1);
    txn(1'b0, 64'h3000, 32'h0, 4'h0, 3'b111, 1'b0, 1, 2, 1'b1, 32'h0, 3);
    txn(1'b0, 64'h4000, 32'h0, 4'h0, 3'b000, 1'b0, 0, 100, 1'b0, 32'h0, 2);
    txn(1'b1, 64'h5000, 32'hCAFEF00D, 4'h3, 3'b100, 1'b1, 2, 3, 1'b0, 32'h0, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 64'h6000;
    bus.cn_ready  = 1'b1;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    bus.cn_ready  = 1'b0;
    bus.rn_rxrsp  = {1'b1, 1'b0, 32'h77};
    #2 preset = 1'b1;
    #1;
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_rn_valid", bus.rn_valid, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rdata", bus.rsp_rdata, 0);
    chk("arst_err", {bus.rsp_err, bus.rsp_timeout}, 0);
    @(negedge pclk);
    @(negedge pclk);
    preset       = 1'b0;
    bus.rn_rxrsp = '0;
    @(negedge pclk);
    chk("arst_no_cpl", bus.rsp_valid, 0);
    txn(1'b0, 64'h7000, 32'h0, 4'h0, 3'b010, 1'b0, 0, 1, 1'b0, 32'hA1B2C3D4, 0);
    txn(1'b0, 64'h8000, 32'h0, 4'h0, 3'b000, 1'b1, 1, T - 1, 1'b1, 32'h0, 1);
    txn(1'b0, 64'h9000, 32'h0, 4'h0, 3'b011, 1'b0, 0, T - 1, 1'b0, 32'h0BADCAFE, 0);
    txn(1'b1, 64'hA000, 32'h11223344, 4'h9, 3'b110, 1'b0, 0, T, 1'b0, 32'h0, 1);
    for (int i = 0; i < 24; i++) begin
      txn(1'($urandom), {$urandom, $urandom}, $urandom, SW'($urandom), 3'($urandom), 1'($urandom),
          $urandom_range(0, 4), $urandom_range(0, T + 2), 1'($urandom), $urandom, $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
